// File: rtl/seq_u_arrbam_mul.sv
// Sequential unsigned broken-array multiplier: one partial-product row per clock.
// Optional macro BAM_EXACT_MODE_EN adds an 'exact' input that bypasses both break levels.
module seq_u_arrbam_mul #(
    parameter int WIDTH = 8,
    parameter int H_CUT = 0,
    parameter int V_CUT = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef BAM_EXACT_MODE_EN
    input  logic                 exact,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam int RW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(WIDTH - 1);
    localparam logic [RW-1:0] H_START  = RW'(H_CUT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 exact_q, exact_d;
    logic                 exact_in_s;
    logic [WIDTH-1:0]     a_mask_s;
    logic [2*WIDTH-1:0]   partial_s;

`ifdef BAM_EXACT_MODE_EN
    assign exact_in_s = exact;
`else
    assign exact_in_s = 1'b0;
`endif

    // Current row: multiplicand columns below the vertical break are dropped, then shifted by row index.
    always_comb begin
        a_mask_s  = '0;
        partial_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            a_mask_s[i] = a_q[i] & (exact_q | ((i + int'(row_q)) >= V_CUT));
        end
        if (b_q[row_q]) begin
            partial_s = {{WIDTH{1'b0}}, a_mask_s} << row_q;
        end else begin
            partial_s = '0;
        end
    end

    // Next-state and datapath update; flush overrides every other request.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        row_d   = row_q;
        exact_d = exact_q;
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b;
                        acc_d   = '0;
                        exact_d = exact_in_s;
                        row_d   = exact_in_s ? {RW{1'b0}} : H_START;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    acc_d = acc_q + partial_s;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = BUSY;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    row_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            row_q   <= '0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            exact_q <= exact_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = acc_q;

endmodule

// File: tb/tb_seq_u_arrbam_mul.sv
// Self-checking bench for seq_u_arrbam_mul: default, H_CUT=2/V_CUT=0 and exact (0/0) instances run in lockstep.
module tb_seq_u_arrbam_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        ex_i = 1'b0;
    logic [7:0]  a_i = 8'd0;
    logic [7:0]  b_i = 8'd0;
    logic        ir_s [3];
    logic        ov_s [3];
    logic [15:0] o_s  [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_u_arrbam_mul #(.WIDTH(8), .H_CUT(0), .V_CUT(10)) dut0 (
        .clk(clk), .rst_n(rst_n),
`ifdef BAM_EXACT_MODE_EN
        .exact(ex_i),
`endif
        .in_valid(in_valid), .in_ready(ir_s[0]), .a(a_i), .b(b_i), .flush(flush),
        .out_valid(ov_s[0]), .out_ready(out_ready), .out(o_s[0]));

    seq_u_arrbam_mul #(.WIDTH(8), .H_CUT(2), .V_CUT(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef BAM_EXACT_MODE_EN
        .exact(1'b0),
`endif
        .in_valid(in_valid), .in_ready(ir_s[1]), .a(a_i), .b(b_i), .flush(flush),
        .out_valid(ov_s[1]), .out_ready(out_ready), .out(o_s[1]));

    seq_u_arrbam_mul #(.WIDTH(8), .H_CUT(0), .V_CUT(0)) dut2 (
        .clk(clk), .rst_n(rst_n),
`ifdef BAM_EXACT_MODE_EN
        .exact(1'b0),
`endif
        .in_valid(in_valid), .in_ready(ir_s[2]), .a(a_i), .b(b_i), .flush(flush),
        .out_valid(ov_s[2]), .out_ready(out_ready), .out(o_s[2]));

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Direct sum of the retained partial-product bits.
    function automatic longint ref_mul(input logic [7:0] x, input logic [7:0] y,
                                       input int h, input int v, input logic ex);
        longint s = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (x[i] && y[j] && (ex || (j >= h && i + j >= v)))
                    s += longint'(1) << (i + j);
        return s;
    endfunction

    task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic ex,
                      input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                      input int hold);
        logic [15:0] exp [3];
        int lat [3];
        int elat [3];
        exp  = '{e0, e1, e2};
        elat = '{8, 6, 8};
        lat  = '{-1, -1, -1};
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("in_ready_idle%0d", d), ir_s[d], 1);
        a_i = ta; b_i = tb; ex_i = ex; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            for (int d = 0; d < 3; d++) if (lat[d] < 0 && ov_s[d]) lat[d] = k;
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
            a_i = 8'($urandom); b_i = 8'($urandom); ex_i = 1'($urandom);
            @(negedge clk);
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("latency%0d", d), lat[d], elat[d]);
            chk($sformatf("out%0d a=%0d b=%0d", d, ta, tb), o_s[d], exp[d]);
        end
        for (int c = 0; c < hold; c++) begin
            a_i = 8'($urandom); b_i = 8'($urandom);
            @(negedge clk);
            chk("hold_out", o_s[0], exp[0]);
            chk("hold_valid", ov_s[0], 1);
            chk("hold_in_ready", ir_s[0], 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("release_valid%0d", d), ov_s[d], 0);
            chk($sformatf("release_ready%0d", d), ir_s[d], 1);
        end
    endtask

    task automatic start_and_run4(input logic [7:0] ta, input logic [7:0] tb);
        @(negedge clk);
        a_i = ta; b_i = tb; ex_i = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    vec_t vt [7];

    initial begin
        logic [7:0] ra, rb;
        logic       rx;
        vt[0] = '{8'd255, 8'd255, 16'd58368, 16'd64260, 16'd65025};
        vt[1] = '{8'd128, 8'd8,   16'd1024,  16'd1024,  16'd1024};
        vt[2] = '{8'd64,  8'd8,   16'd0,     16'd512,   16'd512};
        vt[3] = '{8'd1,   8'd1,   16'd0,     16'd0,     16'd1};
        vt[4] = '{8'd3,   8'd3,   16'd0,     16'd0,     16'd9};
        vt[5] = '{8'd255, 8'd128, 16'd31744, 16'd32640, 16'd32640};
        vt[6] = '{8'd0,   8'd255, 16'd0,     16'd0,     16'd0};

        #1;
        chk("reset_in_ready", ir_s[0], 1);
        chk("reset_out_valid", ov_s[0], 0);
        chk("reset_out", o_s[0], 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++) op(vt[t].a, vt[t].b, 1'b0, vt[t].e0, vt[t].e1, vt[t].e2, t % 2);

        // Long back-pressure hold.
        op(8'd255, 8'd255, 1'b0, 16'd58368, 16'd64260, 16'd65025, 5);

        // Flush in the middle of the row sweep.
        start_and_run4(8'd200, 8'd100);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", ov_s[0], 0);
        chk("flush_ready", ir_s[0], 1);
        chk("flush_out", o_s[0], 0);
        repeat (9) @(negedge clk);
        chk("flush_stays_idle", ov_s[0], 0);
        op(8'd255, 8'd255, 1'b0, 16'd58368, 16'd64260, 16'd65025, 0);

        // Asynchronous reset in the middle of the row sweep.
        start_and_run4(8'd200, 8'd100);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", ir_s[0], 1);
        chk("arst_valid", ov_s[0], 0);
        chk("arst_out", o_s[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(8'd255, 8'd255, 1'b0, 16'd58368, 16'd64260, 16'd65025, 0);

`ifdef BAM_EXACT_MODE_EN
        op(8'd255, 8'd255, 1'b1, 16'd65025, 16'd64260, 16'd65025, 0);
        op(8'd255, 8'd255, 1'b0, 16'd58368, 16'd64260, 16'd65025, 0);
`endif

        for (int r = 0; r < 30; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
`ifdef BAM_EXACT_MODE_EN
            rx = 1'($urandom);
`else
            rx = 1'b0;
`endif
            op(ra, rb, rx,
               16'(ref_mul(ra, rb, 0, 10, rx)),
               16'(ref_mul(ra, rb, 2, 0, 1'b0)),
               16'(ref_mul(ra, rb, 0, 0, 1'b0)),
               int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
